key_led_mode: RTL

//  Consumer of the debounced key stage. Takes one-cycle key press pulses and drives 4 LEDs.

---
 rtl/key_led_mode_if.sv | 23 ++
 rtl/key_led_mode.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/key_led_mode_if.sv
// key_led_mode_if: groups the key press pulses and the LED/mode/speed
// outputs of key_led_mode. The slave modport is the LED controller; the
// master modport is whoever drives the keys and watches the display.
interface key_led_mode_if;
    logic [3:0] key_flag;
    logic [3:0] led_out;
    logic [1:0] mode;
    logic [1:0] speed;

    modport master (
        output key_flag,
        input  led_out,
        input  mode,
        input  speed
    );

    modport slave (
        input  key_flag,
        output led_out,
        output mode,
        output speed
    );
endinterface

// File: rtl/key_led_mode.sv
// key_led_mode: turns debounced key press pulses into a 4-LED display.
// key_flag[0]/[1] step the display mode forward/backward
// (OFF, ALL_ON, BLINK, RUN). key_flag[3]/[2] slow down/speed up the
// animation, whose step period is BASE_TICKS << speed.
// Optional feature macro: KEY_LED_PINGPONG_EN -- when defined, RUN mode
// bounces the lit LED between the ends instead of rotating it.
module key_led_mode #(
    parameter int BASE_TICKS = 6_250_000,
    parameter int CNT_W      = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    key_led_mode_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ALL_ON = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_RUN    = 2'd3
    } mode_t;

    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_TICKS);

    mode_t            r_mode;
    mode_t            w_mode_nxt;
    logic [1:0]       r_speed;
    logic [1:0]       w_speed_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_period;
    logic [3:0]       r_led;
    logic [3:0]       w_led_nxt;
    logic             w_tick;
    logic             w_mode_chg;
    logic             w_key_next;
    logic             w_key_prev;
    logic             w_key_fast;
    logic             w_key_slow;
`ifdef KEY_LED_PINGPONG_EN
    logic             r_dir_up;
    logic             w_dir_up_nxt;
`endif

    // Simultaneous opposing keys cancel, so only "alone" presses act.
    assign w_key_next = bus.key_flag[0] & ~bus.key_flag[1];
    assign w_key_prev = bus.key_flag[1] & ~bus.key_flag[0];
    assign w_key_fast = bus.key_flag[2] & ~bus.key_flag[3];
    assign w_key_slow = bus.key_flag[3] & ~bus.key_flag[2];
    assign w_mode_chg = w_key_next | w_key_prev;

    // ">=" (not "==") lets a speed-up that shrinks the period below the
    // current count fire a step on the very next cycle.
    assign w_period = BASE << r_speed;
    assign w_tick   = (r_cnt >= (w_period - CNT_W'(1)));

    // Next-state for mode, speed, tick counter and LED pattern.
    always_comb begin
        w_mode_nxt  = r_mode;
        w_speed_nxt = r_speed;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_led_nxt   = r_led;
`ifdef KEY_LED_PINGPONG_EN
        w_dir_up_nxt = r_dir_up;
`endif

        if (w_key_next) begin
            w_mode_nxt = mode_t'(r_mode + 2'd1);
        end else if (w_key_prev) begin
            w_mode_nxt = mode_t'(r_mode - 2'd1);
        end

        if (w_key_slow && (r_speed != 2'd3)) begin
            w_speed_nxt = r_speed + 2'd1;
        end else if (w_key_fast && (r_speed != 2'd0)) begin
            w_speed_nxt = r_speed - 2'd1;
        end

        // A mode change beats a coincident tick: load the entry pattern and
        // restart the period so the first step is a full period away.
        if (w_mode_chg) begin
            w_cnt_nxt = '0;
            case (w_mode_nxt)
                MODE_OFF:    w_led_nxt = 4'b0000;
                MODE_ALL_ON: w_led_nxt = 4'b1111;
                MODE_BLINK:  w_led_nxt = 4'b1111;
                MODE_RUN:    w_led_nxt = 4'b0001;
                default:     w_led_nxt = 4'b0000;
            endcase
`ifdef KEY_LED_PINGPONG_EN
            w_dir_up_nxt = 1'b1;
`endif
        end else if (w_tick) begin
            w_cnt_nxt = '0;
            case (r_mode)
                MODE_BLINK: w_led_nxt = ~r_led;
                MODE_RUN: begin
`ifdef KEY_LED_PINGPONG_EN
                    // Reverse at the end LED so it is lit for one step only.
                    if (r_dir_up) begin
                        if (r_led[3]) begin
                            w_led_nxt    = 4'b0100;
                            w_dir_up_nxt = 1'b0;
                        end else begin
                            w_led_nxt = {r_led[2:0], 1'b0};
                        end
                    end else begin
                        if (r_led[0]) begin
                            w_led_nxt    = 4'b0010;
                            w_dir_up_nxt = 1'b1;
                        end else begin
                            w_led_nxt = {1'b0, r_led[3:1]};
                        end
                    end
`else
                    w_led_nxt = {r_led[2:0], r_led[3]};
`endif
                end
                default: w_led_nxt = r_led;
            endcase
        end
    end

    // State registers; reset takes effect immediately, mid-step or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_OFF;
            r_speed <= 2'd0;
            r_cnt   <= '0;
            r_led   <= 4'b0000;
`ifdef KEY_LED_PINGPONG_EN
            r_dir_up <= 1'b1;
`endif
        end else begin
            r_mode  <= w_mode_nxt;
            r_speed <= w_speed_nxt;
            r_cnt   <= w_cnt_nxt;
            r_led   <= w_led_nxt;
`ifdef KEY_LED_PINGPONG_EN
            r_dir_up <= w_dir_up_nxt;
`endif
        end
    end

    assign bus.led_out = r_led;
    assign bus.mode    = r_mode;
    assign bus.speed   = r_speed;

endmodule
